// File: rtl/add_seq_ctrl.sv
// Operand-pair sequencer for the 32-bit adder: reads A/B pairs from the operand
// SRAM, presents them to the adder and writes each sum back to the result region.
module add_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] rd_start_addr_i,
    input  logic [ADDR_W-1:0] rd_end_addr_i,
    input  logic [ADDR_W-1:0] wr_start_addr_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    input  logic [DATA_W-1:0] sum_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        ADD,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   ONE_X = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   TWO_X = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] op_a_d, op_b_d;

    // Pair-availability compares are kept one bit wider so pointer growth past
    // the top of the address space ends the run instead of wrapping.
    logic [ADDR_W:0] first_pair_hi;
    logic [ADDR_W:0] next_rd;
    logic [ADDR_W:0] next_pair_hi;

    assign first_pair_hi = {1'b0, rd_start_addr_i} + ONE_X;
    assign next_rd       = {1'b0, rd_ptr_q} + TWO_X;
    assign next_pair_hi  = next_rd + ONE_X;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            end_q    <= '0;
            op_a_o   <= '0;
            op_b_o   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            end_q    <= end_d;
            op_a_o   <= op_a_d;
            op_b_o   <= op_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        end_d       = end_q;
        op_a_d      = op_a_o;
        op_b_d      = op_b_o;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        busy_o      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rd_ptr_d = rd_start_addr_i;
                    wr_ptr_d = wr_start_addr_i;
                    end_d    = rd_end_addr_i;
                    if (first_pair_hi > {1'b0, rd_end_addr_i}) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_A;
                    end
                end
            end
            RD_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rd_ptr_q;
                state_d    = RD_B;
            end
            RD_B: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rd_ptr_q + ONE_A;
                op_a_d     = mem_rdata_i;
                state_d    = ADD;
            end
            ADD: begin
                op_b_d  = mem_rdata_i;
                state_d = WR;
            end
            WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wr_ptr_q;
                mem_wdata_o = sum_i;
                rd_ptr_d    = next_rd[ADDR_W-1:0];
                wr_ptr_d    = wr_ptr_q + ONE_A;
                if (next_pair_hi <= {1'b0, end_q}) begin
                    state_d = RD_A;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed + randomized bench for add_seq_ctrl with an SRAM model, an adder model
// and a pair-sum reference computed directly from the operand range.
module tb_add_seq_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [9:0]  rd_start_addr_i;
    logic [9:0]  rd_end_addr_i;
    logic [9:0]  wr_start_addr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic [31:0] sum_i;
    logic        busy_o;
    logic        done_o;

    add_seq_ctrl #(
        .ADDR_W(10),
        .DATA_W(32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .rd_start_addr_i(rd_start_addr_i),
        .rd_end_addr_i  (rd_end_addr_i),
        .wr_start_addr_i(wr_start_addr_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .op_a_o         (op_a_o),
        .op_b_o         (op_b_o),
        .sum_i          (sum_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sum_i = op_a_o + op_b_o;

    logic [31:0] mem [1024];

    // Read data is only meaningful one cycle after a read; otherwise it is noise.
    always @(posedge clk) begin
        if (mem_req_o && mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        if (mem_req_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
        else mem_rdata_i <= $urandom;
    end

    logic [9:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    logic [9:0]  rlog   [$];
    int          idle_viol = 0;

    always @(negedge clk) begin
        if (mem_req_o && mem_we_o) begin
            wlog_a.push_back(mem_addr_o);
            wlog_d.push_back(mem_wdata_o);
        end
        if (mem_req_o && !mem_we_o) rlog.push_back(mem_addr_o);
        if (!mem_req_o && (mem_we_o || mem_addr_o != '0 || mem_wdata_o != '0)) idle_viol++;
    end

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int rs, input int re, input int ws, input int inj,
                       input bit start_at_done);
        logic [31:0] expd [$];
        logic [31:0] s;
        int n, cyc, wb, rb, vb;
        for (int p = rs; p + 1 <= re; p += 2) begin
            s = mem[10'(p)] + mem[10'(p + 1)];
            expd.push_back(s);
        end
        n  = expd.size();
        wb = wlog_a.size();
        rb = rlog.size();
        vb = idle_viol;

        @(negedge clk);
        start_i         = 1'b1;
        rd_start_addr_i = 10'(rs);
        rd_end_addr_i   = 10'(re);
        wr_start_addr_i = 10'(ws);
        @(negedge clk);
        start_i = 1'b0;
        cyc     = 1;
        while (done_o !== 1'b1 && cyc < 4 * n + 8) begin
            chk("busy_running", 32'(busy_o), 32'd1);
            if (cyc == inj) begin
                start_i         = 1'b1;
                rd_start_addr_i = 10'd100;
                rd_end_addr_i   = 10'd101;
                wr_start_addr_i = 10'd200;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("run_cycles", 32'(cyc), 32'(4 * n + 1));
        chk("busy_at_done", 32'(busy_o), 32'd1);
        if (start_at_done) begin
            start_i         = 1'b1;
            rd_start_addr_i = 10'(rs);
            rd_end_addr_i   = 10'(re);
            wr_start_addr_i = 10'(ws);
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("done_single", 32'(done_o), 32'd0);
        chk("idle_after", 32'(busy_o), 32'd0);
        chk("req_idle", 32'(mem_req_o), 32'd0);
        chk("write_count", 32'(wlog_a.size() - wb), 32'(n));
        for (int i = 0; i < n && wb + i < wlog_a.size(); i++) begin
            chk("wr_addr", 32'(wlog_a[wb + i]), 32'((ws + i) % 1024));
            chk("wr_data", wlog_d[wb + i], expd[i]);
            chk("mem_result", mem[10'(ws + i)], expd[i]);
        end
        chk("read_count", 32'(rlog.size() - rb), 32'(2 * n));
        for (int i = 0; i < 2 * n && rb + i < rlog.size(); i++) begin
            chk("rd_addr", 32'(rlog[rb + i]), 32'(rs + i));
        end
        chk("idle_outputs_zero", 32'(idle_viol - vb), 32'd0);
    endtask

    initial begin
        int rs, len, ws, wb;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Reset held with start asserted: nothing may move.
        rst_ni          = 1'b0;
        start_i         = 1'b1;
        rd_start_addr_i = 10'd0;
        rd_end_addr_i   = 10'd1;
        wr_start_addr_i = 10'd16;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req", 32'(mem_req_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_we", 32'(mem_we_o), 32'd0);
            chk("rst_addr", 32'(mem_addr_o), 32'd0);
            chk("rst_wdata", mem_wdata_o, 32'd0);
            chk("rst_op_a", op_a_o, 32'd0);
            chk("rst_op_b", op_b_o, 32'd0);
        end
        start_i = 1'b0;
        rst_ni  = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_req", 32'(mem_req_o), 32'd0);

        // Single pair.
        mem[0] = 32'd5;
        mem[1] = 32'd7;
        run(0, 1, 16, 0, 1'b0);
        chk("single_sum", mem[16], 32'd12);
        chk("single_op_a", op_a_o, 32'd5);
        chk("single_op_b", op_b_o, 32'd7);

        // Three pairs, two overflowing.
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1;
        mem[2] = 32'd10;        mem[3] = 32'd20;
        mem[4] = 32'h8000_0000; mem[5] = 32'h8000_0000;
        run(0, 5, 32, 0, 1'b0);
        chk("ovf_r0", mem[32], 32'd0);
        chk("ovf_r1", mem[33], 32'd30);
        chk("ovf_r2", mem[34], 32'd0);

        // Odd count, then empty range.
        for (int i = 0; i < 5; i++) mem[i] = $urandom;
        run(0, 4, 40, 0, 1'b0);
        run(3, 3, 48, 0, 1'b0);

        // Start pulsed during the second pair must be ignored.
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        mem[200] = 32'hDEAD_BEEF;
        run(0, 7, 56, 6, 1'b0);
        chk("inject_untouched", mem[200], 32'hDEAD_BEEF);

        // Start coincident with done is ignored; next run starts from IDLE.
        run(8, 11, 64, 0, 1'b1);
        run(12, 15, 68, 0, 1'b0);

        // Top-of-address-space ranges.
        run(1020, 1023, 600, 0, 1'b0);
        run(1021, 1023, 610, 0, 1'b0);
        run(1022, 1023, 612, 0, 1'b0);
        run(1023, 1023, 620, 0, 1'b0);

        // Randomized ranges.
        for (int k = 0; k < 8; k++) begin
            rs  = int'($urandom_range(200, 1));
            len = int'($urandom_range(12, 0));
            ws  = int'($urandom_range(900, 512));
            for (int i = 0; i < len; i++) mem[10'(rs + i)] = $urandom;
            run(rs, rs + len - 1, ws, 0, 1'b0);
        end

        // Reset during WR of the first pair.
        wb = wlog_a.size();
        @(negedge clk);
        start_i         = 1'b1;
        rd_start_addr_i = 10'd60;
        rd_end_addr_i   = 10'd63;
        wr_start_addr_i = 10'd700;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done_o), 32'd0);
            chk("midrst_no_req", 32'(mem_req_o), 32'd0);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 32'(busy_o), 32'd0);
        chk("midrst_no_write", 32'(wlog_a.size() - wb), 32'd0);
        run(60, 63, 700, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
